// File: rtl/ccu_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : ccu_tx_arb
// Brief    : Round-robin arbiter that shares the CCU packer (SPI return path)
//            between the sys/dac/adc response handlers. It grants one
//            requester per packet, strobes its header to the packer, streams
//            exactly `length` payload bytes, and holds the grant until the
//            packer is no longer busy.
// Options  : define CCU_ARB_TIMEOUT_EN to build the requester-stall watchdog
//            (limit set by TIMEOUT). Without it, DATA waits indefinitely.
// Revision : 1.0  initial release
// ============================================================================
module ccu_tx_arb #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [8*N_REQ-1:0]  req_type,
  input  logic [16*N_REQ-1:0] req_id,
  input  logic [13*N_REQ-1:0] req_length,
  input  logic [8*N_REQ-1:0]  req_tdata,
  input  logic [N_REQ-1:0]    req_tvalid,
  input  logic [N_REQ-1:0]    req_tlast,
  output logic [N_REQ-1:0]    req_tready,
  output logic [N_REQ-1:0]    grant,
  output logic                pack_en,
  output logic [7:0]          pack_type,
  output logic [15:0]         pack_id,
  output logic [12:0]         pack_length,
  output logic [7:0]          pack_data,
  output logic                pack_dvalid,
  input  logic                pack_dready,
  input  logic                pack_busy,
  output logic                len_err,
  output logic                timeout,
  output logic                pack_abort
);

  // Index width for the round-robin pointer and the granted requester.
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra bit so pointer + offset never overflows before the wrap.
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [12:0]      cnt_q, cnt_d;
  logic [7:0]       type_q, type_d;
  logic [15:0]      id_q, id_d;
  logic [12:0]      len_q, len_d;

  // Per-requester views of the flattened buses.
  logic [7:0]  type_arr [N_REQ];
  logic [15:0] id_arr   [N_REQ];
  logic [12:0] len_arr  [N_REQ];
  logic [7:0]  data_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign type_arr[k] = req_type[k*8 +: 8];
    assign id_arr[k]   = req_id[k*16 +: 16];
    assign len_arr[k]  = req_length[k*13 +: 13];
    assign data_arr[k] = req_tdata[k*8 +: 8];
  end

  // Payload signals of the current owner.
  logic       sel_tvalid;
  logic       sel_tlast;
  logic [7:0] sel_tdata;
  logic       beat;

  assign sel_tvalid = req_tvalid[gidx_q];
  assign sel_tlast  = req_tlast[gidx_q];
  assign sel_tdata  = data_arr[gidx_q];
  assign beat       = (state_q == ST_DATA) && sel_tvalid && pack_dready;

  // Round-robin scan: first asserted request at or after rr_ptr, wrapping.
  // Scanning from the far end downward leaves the nearest hit in scan_idx.
  logic [SW-1:0] scan_sum;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] win_idx;

  // Find the winning requester for the next grant.
  always_comb begin
    scan_sum = '0;
    scan_idx = '0;
    win_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr_q} + SW'(i);
      if (scan_sum >= SW'(N_REQ)) begin
        scan_sum = scan_sum - SW'(N_REQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (req[scan_idx]) begin
        win_idx = scan_idx;
      end
    end
  end

  // Requester-stall watchdog: only cycles where the packer is ready but the
  // owner has no byte count; any beat or packer stall restarts the count.
  logic stall_hit;
`ifdef CCU_ARB_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;

  // Count consecutive requester stalls while streaming payload.
  always_comb begin
    stall_d   = '0;
    stall_hit = 1'b0;
    if ((state_q == ST_DATA) && pack_dready && !sel_tvalid) begin
      stall_d   = stall_q + 16'd1;
      stall_hit = (stall_d == 16'(TIMEOUT));
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Next-state and output decode of the grant FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    id_d        = id_q;
    len_d       = len_q;
    pack_en     = 1'b0;
    pack_data   = 8'd0;
    pack_dvalid = 1'b0;
    req_tready  = '0;
    len_err     = 1'b0;
    timeout     = 1'b0;
    pack_abort  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req && !pack_busy) begin
          gidx_d  = win_idx;
          grant_d = N_REQ'(1) << win_idx;
          type_d  = type_arr[win_idx];
          id_d    = id_arr[win_idx];
          len_d   = len_arr[win_idx];
          state_d = ST_HDR;
        end
      end

      ST_HDR: begin
        pack_en = 1'b1;
        cnt_d   = len_q;
        state_d = (len_q != 13'd0) ? ST_DATA : ST_DRAIN;
      end

      ST_DATA: begin
        pack_data   = sel_tdata;
        pack_dvalid = sel_tvalid;
        req_tready  = N_REQ'(pack_dready) << gidx_q;
        if (beat) begin
          cnt_d = cnt_q - 13'd1;
          if (cnt_q == 13'd1) begin
            // Final counted byte: tlast must accompany it.
            len_err = !sel_tlast;
            state_d = ST_DRAIN;
          end else if (sel_tlast) begin
            // Requester ended early; tell the packer the packet is short.
            len_err    = 1'b1;
            pack_abort = 1'b1;
            state_d    = ST_DRAIN;
          end
        end else if (stall_hit) begin
          timeout    = 1'b1;
          pack_abort = 1'b1;
          state_d    = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!pack_busy) begin
          grant_d  = '0;
          rr_ptr_d = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset silences every strobe and handshake, including a would-be abort.
    if (rst) begin
      pack_en     = 1'b0;
      pack_data   = 8'd0;
      pack_dvalid = 1'b0;
      req_tready  = '0;
      len_err     = 1'b0;
      timeout     = 1'b0;
      pack_abort  = 1'b0;
    end
  end

  // State, pointer, grant, counter and header registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      type_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      id_q     <= id_d;
      len_q    <= len_d;
    end
  end

  assign grant       = grant_q;
  assign pack_type   = type_q;
  assign pack_id     = id_q;
  assign pack_length = len_q;

endmodule
`default_nettype wire
